raster_scheduler: RTL and testbench
===================================

Name: raster_scheduler

Overview:
- Sits between the MicroBlaze command path and the triangle rasterizer.
- Buffers incoming triangle descriptors in a small FIFO and presents one descriptor at a time, held stable on the rasterizer inputs.
- Pulses the rasterizer start and waits for its done pulse before presenting the next descriptor.
- Owns the single frame-buffer write port: it muxes the rasterizer writes with a built-in full-screen clear engine.

Parameters:
- DEPTH, 4, triangle FIFO entries (power of two, ≥2).
- FB_WORDS, 76800, frame-buffer pixels (320x240) swept by a clear.
- WDOG_CYCLES, 1048576, watchdog limit in WAIT (used only with the optional feature).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- tri_valid  in  1  descriptor offered.
- tri_ready  out  1  FIFO can accept.
- tri_data  in  230  packed descriptor, MSB→LSB: inv_area[32], color[8], a1,b1,a2,b2,a3,b3[9 each], c1,c2,c3[18 each], bbxi[9], bbxf[9], bbyi[8], bbyf[8], z1,z2,z3[16 each].
- clear_req  in  1  one-cycle request to clear the frame buffer.
- clear_color  in  8  fill value, sampled when the clear starts.
- r_tri  out  230  descriptor to the rasterizer, same packing.
- r_start  out  1  rasterizer start pulse.
- r_done  in  1  rasterizer done pulse.
- r_we  in  1  rasterizer frame-buffer write enable.
- r_din  in  8  rasterizer write data.
- r_addr  in  17  rasterizer write address.
- fb_we  out  1  frame-buffer write enable.
- fb_din  out  8  frame-buffer write data.
- fb_addr  out  17  frame-buffer write address.
- busy  out  1  work outstanding.
- tri_count  out  16  triangles completed since reset, wraps.
- wdog_err  out  1  sticky watchdog flag (tied 0 without the optional feature).

Behaviour:
- Reset (asynchronous, active-high): FIFO emptied; state IDLE; pending clear dropped; r_tri=0, r_start=0, fb_we=0, fb_din=0, fb_addr=0, tri_count=0, wdog_err=0. Because the FIFO is empty, tri_ready=1 once reset deasserts.
- FIFO:
  - Push when tri_valid && tri_ready.
  - tri_ready = !full. No push occurs while full, including a cycle in which a pop also happens.
  - A pop occurs only in LOAD. Push and pop in the same cycle keep the count unchanged.
  - Pointers wrap modulo DEPTH.
- Clear request: clear_req sets a clear_pend flag, which is cleared on entry to CLEAR. Multiple requests before service collapse into one clear.
- State machine (registered):
  - IDLE: if clear_pend → CLEAR (clear has priority over queued triangles); else if FIFO not empty → LOAD.
  - LOAD: r_tri ← FIFO head; pop → START.
  - START: r_start=1 for exactly this cycle → WAIT.
  - WAIT: hold r_tri. When r_done=1, increment tri_count → IDLE. r_done outside WAIT is ignored.
  - CLEAR: on entry latch clear_color and set the counter to 0. Each cycle drive fb_we=1, fb_addr=counter, fb_din=latched color. After address FB_WORDS-1 is written → IDLE. Exactly FB_WORDS writes occur.
- Latency: a descriptor accepted at edge N into an empty, idle block puts the block in LOAD after N+1 and START after N+2. r_start is high between edges N+2 and N+3.
- Frame-buffer port:
  - In CLEAR: driven by the clear engine, and rasterizer inputs are ignored.
  - In all other states: fb_we=r_we, fb_din=r_din, fb_addr=r_addr, passed through combinationally.
  - A clear never starts while a triangle is in flight; a clear_req arriving in WAIT waits for r_done.
- r_tri changes only in LOAD; it is stable from START until the next LOAD.
- busy = (state≠IDLE) || FIFO not empty || clear_pend.
- Reset mid-clear or mid-WAIT aborts immediately. A partially drawn frame is not repaired.

Optional Feature:
- Macro: RASTER_WATCHDOG_EN.
- Defined: a counter runs in WAIT, cleared on entering WAIT. If it reaches WDOG_CYCLES without r_done: set wdog_err (sticky until rst), go to IDLE, and do not increment tri_count. A late r_done is then ignored.
- Undefined: no counter; WAIT lasts indefinitely; wdog_err tied 0.

Test Plan:
- Single triangle, color=0x2A, bbox (10,10)-(12,12) → r_start high between edges N+2 and N+3; r_tri equals tri_data; after a model r_done pulse, tri_count=1 and busy=0.
- Push 5 descriptors back-to-back with DEPTH=4 while the model rasterizer stalls in WAIT → the first is popped to r_tri, so 4 fit in the FIFO. tri_ready drops low after the 5th and no further push occurs while it stays low. All 5 are later started in order; tri_count=5.
- clear_req with color 0x00 while idle → exactly 76800 writes, fb_addr 0..76799 ascending, fb_din=0x00; busy drops the cycle after the last write.
- clear_req during WAIT with 2 triangles queued → the current triangle finishes, then CLEAR runs, then the 2 triangles run. Rasterizer r_we pulses during CLEAR do not appear on fb_we.
- Assert rst during CLEAR at fb_addr=1000 → fb_we=0 immediately, FIFO empty, tri_ready=1, no further writes.
- With RASTER_WATCHDOG_EN and WDOG_CYCLES=64, never pulse r_done → wdog_err=1 after 64 WAIT cycles, the next queued triangle starts, and tri_count is unchanged.

Source files
------------

// File: rtl/raster_scheduler_if.sv
// Bundles the triangle input, rasterizer and frame-buffer signals of raster_scheduler.
// The slave modport is the scheduler's view; master is the environment's.
interface raster_scheduler_if;
  logic         tri_valid;
  logic         tri_ready;
  logic [229:0] tri_data;
  logic         clear_req;
  logic [7:0]   clear_color;
  logic [229:0] r_tri;
  logic         r_start;
  logic         r_done;
  logic         r_we;
  logic [7:0]   r_din;
  logic [16:0]  r_addr;
  logic         fb_we;
  logic [7:0]   fb_din;
  logic [16:0]  fb_addr;
  logic         busy;
  logic [15:0]  tri_count;
  logic         wdog_err;

  modport slave (
    input  tri_valid, tri_data, clear_req, clear_color, r_done, r_we, r_din, r_addr,
    output tri_ready, r_tri, r_start, fb_we, fb_din, fb_addr, busy, tri_count, wdog_err
  );

  modport master (
    output tri_valid, tri_data, clear_req, clear_color, r_done, r_we, r_din, r_addr,
    input  tri_ready, r_tri, r_start, fb_we, fb_din, fb_addr, busy, tri_count, wdog_err
  );
endinterface

// File: rtl/raster_scheduler.sv
// Triangle FIFO + sequencer for the rasterizer, owning the frame-buffer port with a clear engine.
// Optional WAIT watchdog enabled by defining RASTER_WATCHDOG_EN.
module raster_scheduler #(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned FB_WORDS    = 76800,
  parameter int unsigned WDOG_CYCLES = 1048576
) (
  input  logic                  clk,
  input  logic                  rst,
  raster_scheduler_if.slave     bus
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  typedef enum logic [2:0] {StIdle, StLoad, StStart, StWait, StClear} state_e;

  state_e state_q, state_d;

  logic [229:0]    mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]   cnt_q;
  logic            full, empty, push, pop;

  logic [229:0] r_tri_q;
  logic [15:0]  tri_count_q;
  logic         clear_pend_q;
  logic [7:0]   clr_color_q;
  logic [16:0]  clr_cnt_q;
  logic         enter_clear;
  logic         clr_last;
  logic         wdog_hit;

  assign full        = (cnt_q == (PtrW + 1)'(DEPTH));
  assign empty       = (cnt_q == '0);
  assign push        = bus.tri_valid && !full;
  assign pop         = (state_q == StLoad);
  assign enter_clear = (state_q == StIdle) && clear_pend_q;
  assign clr_last    = (clr_cnt_q == 17'(FB_WORDS - 1));

  // FIFO storage carries no reset; only pointers and occupancy matter after reset.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= bus.tri_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (clear_pend_q) state_d = StClear;
        else if (!empty)  state_d = StLoad;
      end
      StLoad:  state_d = StStart;
      StStart: state_d = StWait;
      StWait:  if (bus.r_done || wdog_hit) state_d = StIdle;
      StClear: if (clr_last) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tri_q      <= '0;
      tri_count_q  <= '0;
      clear_pend_q <= 1'b0;
      clr_color_q  <= '0;
      clr_cnt_q    <= '0;
    end else begin
      if (state_q == StLoad) r_tri_q <= mem_q[rd_ptr_q];
      if (state_q == StWait && bus.r_done) tri_count_q <= tri_count_q + 1'b1;
      // Requests landing on the entry cycle merge into the clear being started.
      if (enter_clear)        clear_pend_q <= 1'b0;
      else if (bus.clear_req) clear_pend_q <= 1'b1;
      if (enter_clear) begin
        clr_color_q <= bus.clear_color;
        clr_cnt_q   <= '0;
      end else if (state_q == StClear) begin
        clr_cnt_q <= clr_cnt_q + 1'b1;
      end
    end
  end

`ifdef RASTER_WATCHDOG_EN
  logic [31:0] wdog_cnt_q;
  logic        wdog_err_q;

  assign wdog_hit = (state_q == StWait) && !bus.r_done && (wdog_cnt_q == 32'(WDOG_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wdog_cnt_q <= '0;
      wdog_err_q <= 1'b0;
    end else begin
      if (state_q == StStart)     wdog_cnt_q <= '0;
      else if (state_q == StWait) wdog_cnt_q <= wdog_cnt_q + 1'b1;
      if (wdog_hit) wdog_err_q <= 1'b1;
    end
  end

  assign bus.wdog_err = wdog_err_q;
`else
  assign wdog_hit     = 1'b0;
  assign bus.wdog_err = 1'b0;
`endif

  always_comb begin
    bus.tri_ready = !full;
    bus.r_tri     = r_tri_q;
    bus.r_start   = (state_q == StStart);
    bus.tri_count = tri_count_q;
    bus.busy      = (state_q != StIdle) || !empty || clear_pend_q;
    if (state_q == StClear) begin
      bus.fb_we   = 1'b1;
      bus.fb_din  = clr_color_q;
      bus.fb_addr = clr_cnt_q;
    end else begin
      bus.fb_we   = bus.r_we;
      bus.fb_din  = bus.r_din;
      bus.fb_addr = bus.r_addr;
    end
  end

endmodule

// File: tb/tb_raster_scheduler.sv
// Randomized self-checking bench for raster_scheduler: descriptor scoreboard, model rasterizer,
// frame-buffer write monitor. Watchdog scenario compiled in with RASTER_WATCHDOG_EN.
module tb_raster_scheduler;

  localparam int unsigned FB = 2048;
  localparam int unsigned WD = 64;

  typedef logic [229:0] desc_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  raster_scheduler_if bus ();

  raster_scheduler #(.DEPTH(4), .FB_WORDS(FB), .WDOG_CYCLES(WD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  desc_t exp_q[$];
  desc_t last_started = '0;
  int    starts_seen  = 0;
  int    served       = 0;
  int    exp_count    = 0;

  bit         mon_en   = 1'b0;
  int         wr_cnt   = 0;
  int         wr_err   = 0;
  int         exp_addr = 0;
  logic [7:0] exp_color = '0;

  task automatic check(input string tag, input desc_t got, input desc_t exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic desc_t rand_desc();
    logic [255:0] tmp;
    for (int i = 0; i < 8; i++) tmp[i*32 +: 32] = $urandom;
    return tmp[229:0];
  endfunction

  // Scoreboard: each start must present the oldest accepted, not-yet-started descriptor.
  always @(negedge clk) begin
    if (!rst && bus.r_start) begin
      starts_seen++;
      check("start_expected", desc_t'(exp_q.size() != 0), desc_t'(1));
      if (exp_q.size() != 0) begin
        last_started = exp_q.pop_front();
        check("r_tri_at_start", bus.r_tri, last_started);
      end
    end
    if (!rst && mon_en && bus.fb_we) begin
      if (bus.fb_addr != 17'(exp_addr) || bus.fb_din != exp_color) wr_err++;
      exp_addr++;
      wr_cnt++;
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge; the descriptor is accepted at the following posedge.
  task automatic offer(input desc_t d);
    bus.tri_valid = 1'b1;
    bus.tri_data  = d;
    check("tri_ready_on_offer", desc_t'(bus.tri_ready), desc_t'(1));
    exp_q.push_back(d);
    @(negedge clk);
    bus.tri_valid = 1'b0;
  endtask

  task automatic wait_starts(input int n);
    int t = 0;
    while (starts_seen < n && t < 500) begin
      @(posedge clk);
      t++;
    end
    check("start_within_budget", desc_t'(starts_seen >= n), desc_t'(1));
  endtask

  task automatic pulse_done();
    bus.r_done = 1'b1;
    check("r_tri_held_in_wait", bus.r_tri, last_started);
    @(negedge clk);
    bus.r_done = 1'b0;
    exp_count++;
    served++;
    check("tri_count", desc_t'(bus.tri_count), desc_t'(16'(exp_count)));
  endtask

  task automatic serve(input int n);
    for (int i = 0; i < n; i++) begin
      wait_starts(served + 1);
      cycles(1 + $urandom_range(0, 4));
      pulse_done();
    end
  endtask

  task automatic mon_reset(input logic [7:0] color);
    wr_cnt    = 0;
    wr_err    = 0;
    exp_addr  = 0;
    exp_color = color;
    mon_en    = 1'b1;
  endtask

  task automatic wait_clear_done();
    int t = 0;
    while (wr_cnt < FB && t < FB + 200) begin
      @(posedge clk);
      t++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    desc_t d;
    int    s_before;
    int    wr_snap;
    logic [7:0] c;

    bus.tri_valid   = 1'b0;
    bus.tri_data    = '0;
    bus.clear_req   = 1'b0;
    bus.clear_color = '0;
    bus.r_done      = 1'b0;
    bus.r_we        = 1'b0;
    bus.r_din       = '0;
    bus.r_addr      = '0;

    cycles(3);
    rst = 1'b0;
    @(negedge clk);
    check("reset_tri_ready", desc_t'(bus.tri_ready), desc_t'(1));
    check("reset_busy", desc_t'(bus.busy), desc_t'(0));
    check("reset_r_start", desc_t'(bus.r_start), desc_t'(0));
    check("reset_r_tri", bus.r_tri, desc_t'(0));
    check("reset_tri_count", desc_t'(bus.tri_count), desc_t'(0));
    check("reset_wdog_err", desc_t'(bus.wdog_err), desc_t'(0));
    check("reset_fb_we", desc_t'(bus.fb_we), desc_t'(0));

    // Single triangle: color 0x2A, bbox (10,10)-(12,12); start latency from accept edge N.
    d = rand_desc();
    d[197:190] = 8'h2A;
    d[81:73]   = 9'd10;
    d[72:64]   = 9'd12;
    d[63:56]   = 8'd10;
    d[55:48]   = 8'd12;
    bus.tri_valid = 1'b1;
    bus.tri_data  = d;
    exp_q.push_back(d);
    @(posedge clk);
    @(negedge clk);
    bus.tri_valid = 1'b0;
    check("r_start_after_N", desc_t'(bus.r_start), desc_t'(0));
    @(negedge clk);
    check("r_start_after_N1", desc_t'(bus.r_start), desc_t'(0));
    @(negedge clk);
    check("r_start_after_N2", desc_t'(bus.r_start), desc_t'(1));
    @(negedge clk);
    check("r_start_after_N3", desc_t'(bus.r_start), desc_t'(0));
    check("busy_in_wait", desc_t'(bus.busy), desc_t'(1));
    bus.r_we   = 1'b1;
    bus.r_din  = 8'($urandom);
    bus.r_addr = 17'($urandom);
    #1;
    check("fb_we_pass", desc_t'(bus.fb_we), desc_t'(1));
    check("fb_din_pass", desc_t'(bus.fb_din), desc_t'(bus.r_din));
    check("fb_addr_pass", desc_t'(bus.fb_addr), desc_t'(bus.r_addr));
    bus.r_we = 1'b0;
    serve(1);
    check("busy_after_single", desc_t'(bus.busy), desc_t'(0));

    // Five back-to-back pushes with the rasterizer stalled: one in flight, four queued.
    for (int i = 0; i < 5; i++) offer(rand_desc());
    bus.tri_valid = 1'b1;
    bus.tri_data  = rand_desc();
    for (int i = 0; i < 6; i++) begin
      check("tri_ready_full", desc_t'(bus.tri_ready), desc_t'(0));
      @(negedge clk);
    end
    bus.tri_valid = 1'b0;
    serve(5);
    cycles(3);
    check("queue_drained", desc_t'(exp_q.size()), desc_t'(0));
    check("busy_after_burst", desc_t'(bus.busy), desc_t'(0));

    // Idle clear with color 0x00.
    mon_reset(8'h00);
    bus.clear_color = 8'h00;
    bus.clear_req   = 1'b1;
    @(negedge clk);
    bus.clear_req = 1'b0;
    check("busy_clear_pending", desc_t'(bus.busy), desc_t'(1));
    wait_clear_done();
    @(negedge clk);
    check("busy_after_clear", desc_t'(bus.busy), desc_t'(0));
    check("fb_we_after_clear", desc_t'(bus.fb_we), desc_t'(0));
    check("clear_write_count", desc_t'(wr_cnt), desc_t'(FB));
    check("clear_write_errors", desc_t'(wr_err), desc_t'(0));
    mon_en = 1'b0;

    // Clear requested during WAIT with two triangles queued.
    offer(rand_desc());
    wait_starts(served + 1);
    cycles(2);
    offer(rand_desc());
    offer(rand_desc());
    c = 8'($urandom_range(1, 255));
    mon_reset(c);
    bus.clear_color = c;
    bus.clear_req   = 1'b1;
    @(negedge clk);
    bus.clear_req = 1'b0;
    cycles(5);
    check("no_clear_during_wait", desc_t'(wr_cnt), desc_t'(0));
    s_before = starts_seen;
    pulse_done();
    for (int t = 0; t < int'(FB) + 200 && wr_cnt < FB; t++) begin
      if (wr_cnt > 0) bus.clear_color = ~c;
      bus.r_we   = (wr_cnt > 2 && wr_cnt < FB - 4) ? 1'($urandom) : 1'b0;
      bus.r_din  = 8'hEE;
      bus.r_addr = 17'h1ABCD;
      @(negedge clk);
    end
    bus.r_we = 1'b0;
    check("wait_clear_count", desc_t'(wr_cnt), desc_t'(FB));
    check("wait_clear_errors", desc_t'(wr_err), desc_t'(0));
    check("no_start_during_clear", desc_t'(starts_seen), desc_t'(s_before));
    mon_en = 1'b0;
    serve(2);
    cycles(2);
    check("busy_after_wait_clear", desc_t'(bus.busy), desc_t'(0));

    // Reset in the middle of a clear, with a triangle waiting behind it.
    mon_reset(8'($urandom));
    bus.clear_color = exp_color;
    bus.clear_req   = 1'b1;
    @(negedge clk);
    bus.clear_req = 1'b0;
    offer(rand_desc());
    for (int t = 0; t < 1200 && wr_cnt < 1000; t++) @(posedge clk);
    #1;
    check("fb_addr_before_reset", desc_t'(bus.fb_addr), desc_t'(1000));
    rst = 1'b1;
    #1;
    check("rst_fb_we", desc_t'(bus.fb_we), desc_t'(0));
    check("rst_tri_ready", desc_t'(bus.tri_ready), desc_t'(1));
    check("rst_busy", desc_t'(bus.busy), desc_t'(0));
    check("rst_tri_count", desc_t'(bus.tri_count), desc_t'(0));
    check("rst_r_tri", bus.r_tri, desc_t'(0));
    exp_q.delete();
    exp_count = 0;
    wr_snap   = wr_cnt;
    cycles(3);
    rst    = 1'b0;
    served = starts_seen;
    cycles(50);
    check("no_writes_after_reset", desc_t'(wr_cnt), desc_t'(wr_snap));
    check("no_start_after_reset", desc_t'(starts_seen), desc_t'(served));
    check("busy_after_reset", desc_t'(bus.busy), desc_t'(0));
    mon_en = 1'b0;

`ifdef RASTER_WATCHDOG_EN
    // First triangle never completes; watchdog abandons it and the next one starts.
    offer(rand_desc());
    offer(rand_desc());
    wait_starts(served + 1);
    cycles(40);
    check("wdog_quiet_early", desc_t'(bus.wdog_err), desc_t'(0));
    wait_starts(served + 2);
    #1;
    check("wdog_err_set", desc_t'(bus.wdog_err), desc_t'(1));
    check("wdog_tri_count", desc_t'(bus.tri_count), desc_t'(16'(exp_count)));
    served++;
    cycles(2);
    pulse_done();
    check("wdog_err_sticky", desc_t'(bus.wdog_err), desc_t'(1));
`else
    check("wdog_err_tied", desc_t'(bus.wdog_err), desc_t'(0));
`endif

    check("final_queue_empty", desc_t'(exp_q.size()), desc_t'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
